instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writer side of the instruction memory: accepts a byte stream from the host link and writes the assembled instructions into the instruction memory at consecutive word addresses starting at 0. It sits between the host byte receiver and the instruction memory write port. It holds the CPU (`cpu_hold`) for the whole load so fetch never reads a partially written program.

## Interface
- `PC_WIDTH`, default 32: address width; matches the fetch PC width.
- `MEMORY_SIZE`, default 1024: instruction memory depth in words.
- `INSTRUCTION_WIDTH`, default 32: word width; must be a multiple of 8. BYTES = INSTRUCTION_WIDTH/8.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load; ignored while `busy`=1.
- `word_count` in PC_WIDTH: number of words to load; sampled on `start`.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out PC_WIDTH: word index written (same indexing as fetch `memory[PC]`).
- `mem_wdata` out INSTRUCTION_WIDTH: assembled instruction.
- `busy` out 1: load in progress.
- `cpu_hold` out 1: equal to `busy`; stalls fetch.
- `done` out 1: one-cycle pulse when a load completes.
- `error` out 1: sticky flag for a rejected load; cleared by the next accepted `start`.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- **Reset:** all outputs are 0, state is IDLE, and counters and the shift register are 0. Memory contents are not touched.
- **IDLE, on `start`:**
  - `word_count`=0: go to DONE with no writes; `error` is cleared.
  - `word_count` > MEMORY_SIZE: set `error`, stay in IDLE, no writes.
  - Otherwise: clear `error`, latch the count, set word index to 0 and byte index to 0, go to RECV.
- **RECV:**
  - `in_ready`=1.
  - Each handshake (`in_valid` && `in_ready`) shifts in one byte MSB-first: shreg <= {shreg[W-9:0], `in_data`}. The first byte received ends up as bits [W-1:W-8], matching the compiler's binary image order.
  - On the handshake of byte BYTES-1, go to WRITE.
  - `in_valid`=0 is a stall: state and counters hold indefinitely.
- **WRITE:**
  - `in_ready`=0; `mem_we`=1 for exactly one cycle, with `mem_addr` = word index and `mem_wdata` = shreg.
  - If word index = count-1, go to DONE. Otherwise increment word index, reset byte index, return to RECV.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Flags:** `busy`=1 in RECV, WRITE and DONE.
- **Word index:** never exceeds MEMORY_SIZE-1, because of the `start` check; no wrap-around is possible.
- **Back-pressure:** bytes presented during WRITE, IDLE or DONE are not consumed, since `in_ready`=0.
- **Reset mid-load:** abort immediately. Words already written stay in memory; `done` is not pulsed.

## Timing
- `start` to `in_ready`=1: 1 cycle.
- Last byte handshake to `mem_we`: next cycle.
- Final `mem_we` to `done`: next cycle.
- `done` to `busy`=0: next cycle.
- Maximum throughput: BYTES+1 cycles per word (one byte per cycle plus one write cycle).
- `mem_addr` and `mem_wdata` are registered and stable while `mem_we`=1. Outside WRITE they hold their last values.
- `error` updates the cycle after `start`.

## Structure
- Package `instruction_loader_pkg`:
  - State enum `loader_state_t` (IDLE, RECV, WRITE, DONE).
  - Function `bytes_per_word(width)`.
  - Elaboration check that INSTRUCTION_WIDTH % 8 == 0.
- One sub-module, `word_assembler`: the byte shift register plus byte counter, with inputs shift-enable and clear and output word_full. The FSM and address counter live in the top module.

## Test plan
- **Single word:** `start`, `word_count`=1, bytes 0x00,0x50,0x00,0x93 with `in_valid` held high → `mem_we` once, `mem_addr`=0, `mem_wdata`=0x00500093; `done` 1 cycle later; `busy` low the cycle after.
- **Stalls:** 3 words with `in_valid` toggled randomly → writes at addresses 0,1,2 with correct data; `in_ready` low during each WRITE cycle; no byte lost or duplicated.
- **Bounds:** `word_count`=1025 → `error`=1, no `mem_we`, `busy`=0. `word_count`=0 → `done` pulse, no `mem_we`. `word_count`=1024 → last write at `mem_addr`=1023.
- **Start while busy:** `start` pulsed during RECV → ignored; load completes with the original count.
- **Reset mid-load:** `rst_n` low after word 1, byte 2 → all outputs 0 immediately. A following fresh load of 2 words writes addresses 0 and 1 correctly.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and helpers for the instruction loader: FSM state encoding
// and the bytes-per-instruction calculation.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Byte-to-word assembler: MSB-first shift register plus byte counter.
// word_full flags the handshake that delivers the last byte of a word.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         shift_en,
  input  logic [7:0]   in_byte,
  output logic [W-1:0] word_next,
  output logic         word_full
);

  localparam int BYTES = bytes_per_word(W);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [W-1:0]  shreg_r;
  logic [CW-1:0] cnt_r;

  // First byte received ends up in the top byte once the word is complete
  assign word_next = (shreg_r << 8) | W'(in_byte);
  assign word_full = shift_en && (cnt_r == CW'(BYTES - 1));

  // Shift register and byte counter update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      cnt_r   <= '0;
    end else if (shift_en) begin
      shreg_r <= word_next;
      cnt_r   <= word_full ? '0 : cnt_r + CW'(1);
    end else begin
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a host byte stream into instruction memory at word addresses 0..N-1,
// holding the CPU for the duration of the load.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int PC_WIDTH          = 32,
  parameter int MEMORY_SIZE       = 1024,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          word_count,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         mem_we,
  output logic [PC_WIDTH-1:0]          mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         busy,
  output logic                         cpu_hold,
  output logic                         done,
  output logic                         error
);

  if ((INSTRUCTION_WIDTH % 8) != 0) begin : g_bad_width
    $error("INSTRUCTION_WIDTH must be a multiple of 8");
  end

  loader_state_t                state_r;
  logic [PC_WIDTH-1:0]          count_r;
  logic [PC_WIDTH-1:0]          widx_r;
  logic                         in_ready_r;
  logic                         mem_we_r;
  logic [PC_WIDTH-1:0]          mem_addr_r;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata_r;
  logic                         busy_r;
  logic                         done_r;
  logic                         error_r;

  logic                         shift_en_s;
  logic                         clear_s;
  logic                         word_full_s;
  logic [INSTRUCTION_WIDTH-1:0] word_next_s;

  assign shift_en_s = (state_r == RECV) && in_valid && in_ready_r;
  assign clear_s    = (state_r != RECV);

  word_assembler #(
    .W (INSTRUCTION_WIDTH)
  ) u_word_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .shift_en  (shift_en_s),
    .in_byte   (in_data),
    .word_next (word_next_s),
    .word_full (word_full_s)
  );

  // Load sequencer with registered handshake, write-port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= '0;
      widx_r      <= '0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              error_r <= 1'b0;
              busy_r  <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else if (word_count > PC_WIDTH'(MEMORY_SIZE)) begin
              error_r <= 1'b1;
            end else begin
              error_r    <= 1'b0;
              count_r    <= word_count;
              widx_r     <= '0;
              busy_r     <= 1'b1;
              in_ready_r <= 1'b1;
              state_r    <= RECV;
            end
          end
        end
        RECV: begin
          if (word_full_s) begin
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= widx_r;
            mem_wdata_r <= word_next_s;
            state_r     <= WRITE;
          end
        end
        WRITE: begin
          if (widx_r == count_r - PC_WIDTH'(1)) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            widx_r     <= widx_r + PC_WIDTH'(1);
            in_ready_r <= 1'b1;
            state_r    <= RECV;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign cpu_hold  = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Scenario-driven bench for instruction_loader with a write scoreboard.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  bytes_q[$];
  logic [63:0] exp_q[$];
  int          writes_seen;
  int          last_we_cyc;
  int          done_cyc;
  logic [31:0] last_addr;

  instruction_loader #(
    .PC_WIDTH          (32),
    .MEMORY_SIZE       (1024),
    .INSTRUCTION_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic push_word(input logic [31:0] addr, input logic [31:0] w);
    bytes_q.push_back(w[31:24]);
    bytes_q.push_back(w[23:16]);
    bytes_q.push_back(w[15:8]);
    bytes_q.push_back(w[7:0]);
    exp_q.push_back({addr, w});
  endtask

  // Drives one load; scoreboards writes as they appear. start_at injects a
  // stray start, abort_at asserts reset after that many consumed bytes.
  task automatic run_load(input logic [31:0] n, input int stall, input int start_at,
                          input int abort_at, input int budget);
    int          consumed;
    int          c;
    bit          rdy_prev;
    bit          done_seen;
    logic [63:0] exp;
    consumed = 0; c = 0; rdy_prev = 1'b0; done_seen = 1'b0;
    writes_seen = 0; last_we_cyc = -1; done_cyc = -1;
    @(negedge clk); start = 1'b1; word_count = n;
    @(negedge clk); start = 1'b0;
    while (!done_seen && c < budget) begin
      if (in_valid && rdy_prev) begin
        void'(bytes_q.pop_front());
        consumed++;
      end
      if (abort_at >= 0 && consumed == abort_at) begin
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
          failures++;
          $display("FAIL reset_mid_load flags=%b addr=%h data=%h required all zero",
                   {in_ready, mem_we, busy, cpu_hold, done, error}, mem_addr, mem_wdata);
        end
        return;
      end
      if (mem_we) begin
        writes_seen++; last_we_cyc = cyc; last_addr = mem_addr;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h required none", mem_addr, mem_wdata);
        end else begin
          exp = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp) begin
            failures++;
            $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                     mem_addr, mem_wdata, exp[63:32], exp[31:0]);
          end
        end
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_during_write in_ready=%b required 0", in_ready);
        end
      end
      if (done) begin
        done_seen = 1'b1; done_cyc = cyc;
      end
      if (c == start_at) begin
        start = 1'b1; word_count = 32'd5;
      end else begin
        start = 1'b0;
      end
      in_valid = (bytes_q.size() > 0) && ($urandom_range(99) >= stall);
      in_data  = (bytes_q.size() > 0) ? bytes_q[0] : 8'h00;
      rdy_prev = in_ready;
      c++;
      if (!done_seen) @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL load_timeout done=0 after %0d cycles required done pulse", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; word_count = 32'd0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state flags=%b addr=%h data=%h required all zero",
               {in_ready, mem_we, busy, cpu_hold, done, error}, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    push_word(32'd0, 32'h00500093);
    run_load(32'd1, 0, -1, -1, 50);
    checks++;
    if (writes_seen != 1) begin
      failures++; $display("FAIL single_write_count got=%0d required 1", writes_seen);
    end
    checks++;
    if (done_cyc != last_we_cyc + 1) begin
      failures++;
      $display("FAIL single_done_timing done_cyc=%0d required %0d", done_cyc, last_we_cyc + 1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL single_busy_clear busy=%b hold=%b required 0", busy, cpu_hold);
    end
  endtask

  task automatic test_stalls();
    for (int i = 0; i < 3; i++) push_word(i, $urandom());
    run_load(32'd3, 50, -1, -1, 300);
    checks++;
    if (writes_seen != 3 || exp_q.size() != 0 || bytes_q.size() != 0) begin
      failures++;
      $display("FAIL stall_accounting writes=%0d exp_left=%0d bytes_left=%0d required 3/0/0",
               writes_seen, exp_q.size(), bytes_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_bounds();
    int we_hits;
    we_hits = 0;
    @(negedge clk); start = 1'b1; word_count = 32'd1025;
    @(negedge clk); start = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL oversize_reject error=%b busy=%b required 1/0", error, busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_we) we_hits++;
      @(negedge clk);
    end
    checks++;
    if (we_hits != 0 || error !== 1'b1) begin
      failures++; $display("FAIL oversize_quiet writes=%0d error=%b required 0/1", we_hits, error);
    end
    run_load(32'd0, 0, -1, -1, 10);
    checks++;
    if (writes_seen != 0 || error !== 1'b0) begin
      failures++; $display("FAIL zero_count writes=%0d error=%b required 0/0", writes_seen, error);
    end
    @(negedge clk);
    for (int i = 0; i < 1024; i++) push_word(i, $urandom());
    run_load(32'd1024, 0, -1, -1, 6000);
    checks++;
    if (writes_seen != 1024 || last_addr !== 32'd1023) begin
      failures++;
      $display("FAIL full_memory writes=%0d last_addr=%0d required 1024/1023", writes_seen, last_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    push_word(32'd0, 32'hDEADBEEF);
    push_word(32'd1, 32'h12345678);
    run_load(32'd2, 0, 2, -1, 100);
    checks++;
    if (writes_seen != 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL busy_start_count writes=%0d required 2", writes_seen);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL busy_start_after busy=%b error=%b required 0/0", busy, error);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 3; i++) push_word(i, $urandom());
    run_load(32'd3, 0, -1, 6, 100);
    checks++;
    if (writes_seen != 1) begin
      failures++; $display("FAIL abort_writes got=%0d required 1", writes_seen);
    end
    bytes_q.delete(); exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    push_word(32'd0, 32'hA5A55A5A);
    push_word(32'd1, 32'h0F1E2D3C);
    run_load(32'd2, 30, -1, -1, 200);
    checks++;
    if (writes_seen != 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL reload_count writes=%0d required 2", writes_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stalls();
    test_bounds();
    test_start_while_busy();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
